// File: rtl/seq_detector_prog_if.sv
// Bus bundle for seq_detector_prog: serial input, configuration, counter
// control, and the detect/count/display results.
interface seq_detector_prog_if #(
    parameter int unsigned PRE_LEN    = 2,
    parameter int unsigned NUM_DIGITS = 2
);
    logic                      ena;
    logic                      sig_to_test;
    logic                      cfg_load;
    logic [PRE_LEN-1:0]        cfg_prefix;
    logic                      cfg_fill;
    logic                      cfg_final;
    logic                      cfg_overlap;
    logic                      cnt_clr;
    logic                      z;
    logic [4*NUM_DIGITS-1:0]   count_bcd;
    logic [7*NUM_DIGITS-1:0]   disp;
    logic                      overflow;

    modport master (
        output ena, sig_to_test, cfg_load, cfg_prefix, cfg_fill, cfg_final,
               cfg_overlap, cnt_clr,
        input  z, count_bcd, disp, overflow
    );

    modport slave (
        input  ena, sig_to_test, cfg_load, cfg_prefix, cfg_fill, cfg_final,
               cfg_overlap, cnt_clr,
        output z, count_bcd, disp, overflow
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable Mealy detector for PREFIX, FILL*, FINAL with a BCD detection
// counter and active-low 7-segment display of the count.
module seq_detector_prog #(
    parameter int unsigned        PRE_LEN     = 2,
    parameter int unsigned        NUM_DIGITS  = 2,
    parameter logic [PRE_LEN-1:0] RST_PREFIX  = PRE_LEN'(2'b01),
    parameter logic               RST_FILL    = 1'b0,
    parameter logic               RST_FINAL   = 1'b1,
    parameter logic               RST_OVERLAP = 1'b1,
    parameter logic               SATURATE    = 1'b0,
    parameter logic               BLANK_LZ    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_prog_if.slave   bus
);
    localparam int unsigned VW = $clog2(PRE_LEN + 1);
    localparam int unsigned CW = 4 * NUM_DIGITS;
    localparam int unsigned DW = 7 * NUM_DIGITS;
    localparam logic [VW-1:0] VALID_FULL = VW'(PRE_LEN);

    // Configuration
    logic [PRE_LEN-1:0] r_prefix;
    logic               r_fill;
    logic               r_final;
    logic               r_overlap;

    // Detector state
    logic [PRE_LEN-1:0] r_hist;
    logic [VW-1:0]      r_valid;
    logic               r_armed;

    // Counter and display
    logic [CW-1:0]      r_count;
    logic               r_ovf;
    logic [DW-1:0]      r_disp;

    logic               w_b;
    logic               w_z;
    logic [PRE_LEN-1:0] w_hist_n;
    logic [VW-1:0]      w_valid_n;
    logic               w_pm;
    logic               w_hold;
    logic [PRE_LEN-1:0] w_hist_nx;
    logic [VW-1:0]      w_valid_nx;
    logic               w_armed_nx;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_carry;
    logic [CW-1:0]      w_cnt_nx;
    logic               w_ovf_nx;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b0000111;
        endcase
        return s;
    endfunction

    // Render all digits, most significant first so leading zeros can be tracked
    function automatic logic [DW-1:0] f_render(input logic [CW-1:0] cnt);
        logic [DW-1:0] d;
        logic          lz;
        logic [6:0]    seg;
        d  = '0;
        lz = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            seg = f_seg(cnt[4*k +: 4]);
            lz  = lz & (cnt[4*k +: 4] == 4'd0);
            if (BLANK_LZ && lz && (k != 0)) begin
                seg = 7'b1111111;
            end
            d[7*k +: 7] = seg;
        end
        return d;
    endfunction

    assign w_b       = bus.sig_to_test;
    assign w_z       = bus.ena & r_armed & (w_b == r_final);
    assign w_hist_n  = PRE_LEN'({r_hist, w_b});
    assign w_valid_n = (r_valid == VALID_FULL) ? r_valid : r_valid + VW'(1);
    assign w_pm      = (w_hist_n == r_prefix) & (w_valid_n == VALID_FULL);
    // Fill bits keep the detector armed only when they cannot be mistaken for FINAL
    assign w_hold    = r_armed & (w_b == r_fill) & (r_fill != r_final);

    // Detector next state; a config load wipes the history
    always_comb begin
        w_hist_nx  = r_hist;
        w_valid_nx = r_valid;
        w_armed_nx = r_armed;
        if (bus.cfg_load) begin
            w_hist_nx  = '0;
            w_valid_nx = '0;
            w_armed_nx = 1'b0;
        end else if (bus.ena) begin
            if (w_z && !r_overlap) begin
                w_hist_nx  = '0;
                w_valid_nx = '0;
                w_armed_nx = 1'b0;
            end else if (w_z) begin
                w_hist_nx  = w_hist_n;
                w_valid_nx = w_valid_n;
                w_armed_nx = w_pm;
            end else begin
                w_hist_nx  = w_hist_n;
                w_valid_nx = w_valid_n;
                w_armed_nx = w_pm | w_hold;
            end
        end
    end

    // BCD ripple increment; a carry out of the top digit means the count was all 9s
    always_comb begin
        w_cnt_inc = r_count;
        w_carry   = 1'b1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (w_carry) begin
                if (r_count[4*k +: 4] >= 4'd9) begin
                    w_cnt_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end

        w_cnt_nx = r_count;
        w_ovf_nx = r_ovf;
        if (bus.cnt_clr) begin
            w_cnt_nx = '0;
            w_ovf_nx = 1'b0;
        end else if (w_z) begin
            if (w_carry) begin
                w_ovf_nx = 1'b1;
                w_cnt_nx = SATURATE ? r_count : w_cnt_inc;
            end else begin
                w_cnt_nx = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prefix  <= RST_PREFIX;
            r_fill    <= RST_FILL;
            r_final   <= RST_FINAL;
            r_overlap <= RST_OVERLAP;
        end else if (bus.cfg_load) begin
            r_prefix  <= bus.cfg_prefix;
            r_fill    <= bus.cfg_fill;
            r_final   <= bus.cfg_final;
            r_overlap <= bus.cfg_overlap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist  <= '0;
            r_valid <= '0;
            r_armed <= 1'b0;
        end else begin
            r_hist  <= w_hist_nx;
            r_valid <= w_valid_nx;
            r_armed <= w_armed_nx;
        end
    end

    // Display trails the count by one cycle and refreshes regardless of ena
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_disp  <= f_render(CW'(0));
        end else begin
            r_count <= w_cnt_nx;
            r_ovf   <= w_ovf_nx;
            r_disp  <= f_render(r_count);
        end
    end

    assign bus.z         = w_z;
    assign bus.count_bcd = r_count;
    assign bus.disp      = r_disp;
    assign bus.overflow  = r_ovf;

endmodule
